// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps the select lines of an N-to-1 mux, holding each
// select value for DWELL cycles. At the end of each dwell it samples the mux
// output into a shadow register. When a full word has been collected it is
// presented on data/valid with a valid/ready handshake.
module mux_scan_sequencer #(
    parameter int DWELL = 4,
    parameter int SEL_W = 3,
    localparam int N = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             continuous,
    input  logic             d,
    input  logic             ready,
    output logic [SEL_W-1:0] sel,
    output logic [N-1:0]     data,
    output logic             valid,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // DWELL is at most 255, so an 8-bit dwell counter always covers it.
    localparam logic [7:0]       CNT_LAST = 8'(DWELL - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [N-1:0]     shadow_q, shadow_d;
    logic [N-1:0]     data_q, data_d;
    logic             valid_q, valid_d;

    // Next-state logic: dwell counting, bit capture, word completion and handshake.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = valid_q;

        case (state_q)
            IDLE: begin
                sel_d = '0;
                cnt_d = '0;
                if (start) begin
                    state_d = SCAN;
                end
            end

            SCAN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d           = '0;
                    shadow_d[sel_q] = d;
                    if (sel_q == SEL_LAST) begin
                        // The last bit goes straight from d into data, because
                        // the shadow copy of it only becomes visible next cycle.
                        data_d  = {d, shadow_q[N-2:0]};
                        valid_d = 1'b1;
                        sel_d   = '0;
                        state_d = DONE;
                    end else begin
                        sel_d = sel_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            DONE: begin
                if (valid_q && ready) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    sel_d   = '0;
                    state_d = continuous ? SCAN : IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                sel_d   = '0;
                cnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign sel   = sel_q;
    assign data  = data_q;
    assign valid = valid_q;
    assign busy  = (state_q != IDLE);

endmodule
